// File: rtl/status_engine_fsm_if.sv
// -----------------------------------------------------------------------------
// status_engine_fsm_if
//   Request/response bundle between the rule-insertion controller (master)
//   and the status merge engine (slave).
//
//   i_SET_ID     master->slave  candidate set-ID word
//   i_Status_En  master->slave  request strobe
//   i_RAM_Data   master->slave  set-ID word currently stored in RAM
//   o_SETID_MOD  slave->master  merged set-ID word (registered)
//   o_Done       slave->master  one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
interface status_engine_fsm_if #(
  parameter int VTWID = 130
);
  logic [VTWID-1:0] i_SET_ID;
  logic             i_Status_En;
  logic [VTWID-1:0] i_RAM_Data;
  logic [VTWID-1:0] o_SETID_MOD;
  logic             o_Done;

  modport master (
    output i_SET_ID, i_Status_En, i_RAM_Data,
    input  o_SETID_MOD, o_Done
  );

  modport slave (
    input  i_SET_ID, i_Status_En, i_RAM_Data,
    output o_SETID_MOD, o_Done
  );
endinterface

// File: rtl/status_engine_fsm.sv
// -----------------------------------------------------------------------------
// status_engine_fsm
//   Segment-wise status merge engine for the TCAM set-ID update path. On a
//   request it captures the candidate and stored set-ID words, walks their
//   segments one per clock merging each pair by a fixed priority rule, then
//   publishes the merged word together with a one-cycle done pulse.
//
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   status_engine_fsm_if.slave (request inputs, merged word + done)
//
//   Segment i = bits [i*SEGWID +: SEGWID] = {status[1:0], data[DWID-1:0]}.
//   Status: 00 empty, 01 valid, 10 wildcard, 11 shared/conflict.
// -----------------------------------------------------------------------------
module status_engine_fsm #(
  parameter int KWID   = 104,
  parameter int DWID   = 8,
  parameter int SEGWID = DWID + 2,
  parameter int VTWID  = SEGWID * (KWID / DWID)
) (
  input logic                clk,
  input logic                rst,
  status_engine_fsm_if.slave bus
);

  localparam int NSEG = KWID / DWID;
  localparam int CNTW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CNTW-1:0] LAST_SEG = CNTW'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [VTWID-1:0]  set_id_q, set_id_d;
  logic [VTWID-1:0]  ram_q, ram_d;
  logic [VTWID-1:0]  work_q, work_d;
  logic [VTWID-1:0]  setid_mod_q, setid_mod_d;
  logic              done_q, done_d;
  logic [SEGWID-1:0] merged_seg;
  int                seg_base;

  // Priority merge of one candidate/stored segment pair; first match wins.
  function automatic logic [SEGWID-1:0] merge_seg(
    input logic [SEGWID-1:0] id_seg,
    input logic [SEGWID-1:0] ram_seg
  );
    logic [1:0]      si;
    logic [1:0]      sr;
    logic [DWID-1:0] di;
    logic [DWID-1:0] dr;
    si = id_seg[SEGWID-1 -: 2];
    sr = ram_seg[SEGWID-1 -: 2];
    di = id_seg[DWID-1:0];
    dr = ram_seg[DWID-1:0];
    if (si == 2'b00)                        return ram_seg;
    else if (sr == 2'b00)                   return id_seg;
    else if (si == 2'b10 || sr == 2'b10)    return {2'b10, dr};
    else if (si == 2'b11 || sr == 2'b11)    return {2'b11, dr};
    else if (di == dr)                      return {2'b01, dr};
    else                                    return {2'b11, dr};
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_Status_En) state_d = PROC;
      PROC:    if (cnt_q == LAST_SEG) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  assign seg_base   = int'(cnt_q) * SEGWID;
  assign merged_seg = merge_seg(set_id_q[seg_base +: SEGWID], ram_q[seg_base +: SEGWID]);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    set_id_d    = set_id_q;
    ram_d       = ram_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    setid_mod_d = setid_mod_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_Status_En) begin
          set_id_d = bus.i_SET_ID;
          ram_d    = bus.i_RAM_Data;
          work_d   = '0;
          cnt_d    = '0;
        end
      end
      PROC: begin
        work_d[seg_base +: SEGWID] = merged_seg;
        if (cnt_q == LAST_SEG) begin
          // Publish the full word including the segment merged this cycle.
          setid_mod_d = work_d;
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the wide capture/work registers are plain flops, not a RAM, so they
  // take the asynchronous reset too; a reset mid-request leaves no stale word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      set_id_q    <= '0;
      ram_q       <= '0;
      work_q      <= '0;
      setid_mod_q <= '0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      set_id_q    <= set_id_d;
      ram_q       <= ram_d;
      work_q      <= work_d;
      setid_mod_q <= setid_mod_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (registered values only)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_SETID_MOD = setid_mod_q;
    bus.o_Done      = done_q;
  end

endmodule

// File: tb/tb_status_engine_fsm.sv
module tb_status_engine_fsm;

  localparam int NSEG  = 13;
  localparam int SW    = 10;
  localparam int VTWID = 130;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  status_engine_fsm_if #(.VTWID(VTWID)) bus ();

  status_engine_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request (capture edge E0), scrambles the inputs afterwards and
  // reports edges from E0 to the first o_Done sample (-1 if none within 40),
  // the word presented with it, and whether o_Done dropped on the next edge.
  task automatic run_request(input logic [VTWID-1:0] id, input logic [VTWID-1:0] ram,
                             output int lat, output logic [VTWID-1:0] result,
                             output logic single_pulse);
    bus.i_SET_ID     = id;
    bus.i_RAM_Data   = ram;
    bus.i_Status_En  = 1'b1;
    tick();
    bus.i_Status_En  = 1'b0;
    bus.i_SET_ID     = '1;
    bus.i_RAM_Data   = ~ram;
    lat          = -1;
    result       = '0;
    single_pulse = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.o_Done) begin
        lat    = k;
        result = bus.o_SETID_MOD;
        break;
      end
    end
    if (lat != -1) begin
      tick();
      single_pulse = !bus.o_Done;
    end
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    bus.i_Status_En = 1'b1;
    bus.i_SET_ID    = '1;
    bus.i_RAM_Data  = '1;
    repeat (3) tick();
    vectors++;
    if (bus.o_SETID_MOD !== '0) begin
      miscompares++;
      $display("FAIL reset_word: got %h expected 0", bus.o_SETID_MOD);
    end
    vectors++;
    if (bus.o_Done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", bus.o_Done);
    end
    bus.i_Status_En = 1'b0;
    rst = 1'b1;
    begin
      int done_seen = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (bus.o_Done === 1'b1) done_seen++;
      end
      vectors++;
      if (done_seen != 0) begin
        miscompares++;
        $display("FAIL reset_idle_done: got %0d pulses expected 0", done_seen);
      end
    end
  endtask

  task automatic test_empty_ram();
    logic [VTWID-1:0] id, exp, res;
    int lat;
    logic single;
    for (int i = 0; i < NSEG; i++) begin
      id[i*SW +: SW]  = 10'h1A5;
      exp[i*SW +: SW] = 10'h1A5;
    end
    run_request(id, '0, lat, res, single);
    vectors++;
    if (lat != 13) begin
      miscompares++;
      $display("FAIL empty_latency: got %0d expected 13", lat);
    end
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL empty_word: got %h expected %h", res, exp);
    end
    vectors++;
    if (single !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_pulse_width: got single=%b expected 1", single);
    end
  endtask

  task automatic test_valid_compare();
    logic [VTWID-1:0] id, ram, exp, res;
    int lat;
    logic single;
    id = '0; ram = '0; exp = '0;
    id[0*SW +: SW] = 10'h13C; ram[0*SW +: SW] = 10'h13C; exp[0*SW +: SW] = 10'h13C;
    id[1*SW +: SW] = 10'h13D; ram[1*SW +: SW] = 10'h13C; exp[1*SW +: SW] = 10'h33C;
    id[2*SW +: SW] = 10'h0FF; ram[2*SW +: SW] = 10'h177; exp[2*SW +: SW] = 10'h177;
    run_request(id, ram, lat, res, single);
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL valid_word: got %h expected %h", res, exp);
    end
    vectors++;
    if (lat != 13 || single !== 1'b1) begin
      miscompares++;
      $display("FAIL valid_timing: got lat=%0d single=%b expected 13/1", lat, single);
    end
  endtask

  function automatic logic [VTWID-1:0] wild_id();
    logic [VTWID-1:0] v = '0;
    v[0*SW +: SW]  = 10'h200;
    v[1*SW +: SW]  = 10'h155;
    v[2*SW +: SW]  = 10'h399;
    v[3*SW +: SW]  = 10'h2AB;
    v[12*SW +: SW] = 10'h311;
    return v;
  endfunction

  function automatic logic [VTWID-1:0] wild_ram();
    logic [VTWID-1:0] v = '0;
    v[0*SW +: SW]  = 10'h112;
    v[1*SW +: SW]  = 10'h366;
    v[2*SW +: SW]  = 10'h244;
    v[3*SW +: SW]  = 10'h0CD;
    v[12*SW +: SW] = 10'h122;
    return v;
  endfunction

  function automatic logic [VTWID-1:0] wild_exp();
    logic [VTWID-1:0] v = '0;
    v[0*SW +: SW]  = 10'h212;
    v[1*SW +: SW]  = 10'h366;
    v[2*SW +: SW]  = 10'h244;
    v[3*SW +: SW]  = 10'h2AB;
    v[12*SW +: SW] = 10'h322;
    return v;
  endfunction

  task automatic test_wildcard_shared();
    logic [VTWID-1:0] res;
    int lat;
    logic single;
    run_request(wild_id(), wild_ram(), lat, res, single);
    vectors++;
    if (res !== wild_exp()) begin
      miscompares++;
      $display("FAIL wildcard_word: got %h expected %h", res, wild_exp());
    end
    vectors++;
    if (lat != 13) begin
      miscompares++;
      $display("FAIL wildcard_latency: got %0d expected 13", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [VTWID-1:0] id_a, exp_a, id_b, ram_b, id_c, ram_c, exp_c, res;
    int pulses, first_cyc, lat;
    logic single;
    for (int i = 0; i < NSEG; i++) begin
      id_a[i*SW +: SW]  = 10'h1A5;
      exp_a[i*SW +: SW] = 10'h1A5;
      id_b[i*SW +: SW]  = 10'h2F0;
      ram_b[i*SW +: SW] = 10'h10F;
    end
    id_c = '0; ram_c = '0; exp_c = '0;
    id_c[5*SW +: SW] = 10'h13D; ram_c[5*SW +: SW] = 10'h13C; exp_c[5*SW +: SW] = 10'h33C;
    // Request A captured at E0.
    bus.i_SET_ID = id_a; bus.i_RAM_Data = '0; bus.i_Status_En = 1'b1;
    tick();
    bus.i_Status_En = 1'b0;
    pulses = 0; first_cyc = -1; res = '0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) begin
        bus.i_SET_ID = id_b; bus.i_RAM_Data = ram_b; bus.i_Status_En = 1'b1;
      end
      tick();
      bus.i_Status_En = 1'b0;
      if (bus.o_Done === 1'b1) begin
        pulses++;
        if (first_cyc < 0) begin
          first_cyc = c;
          res = bus.o_SETID_MOD;
        end
      end
    end
    vectors++;
    if (pulses != 1 || first_cyc != 13) begin
      miscompares++;
      $display("FAIL busy_pulses: got %0d pulses first at %0d expected 1 at 13", pulses, first_cyc);
    end
    vectors++;
    if (res !== exp_a) begin
      miscompares++;
      $display("FAIL busy_word: got %h expected %h", res, exp_a);
    end
    vectors++;
    if (bus.o_SETID_MOD !== exp_a) begin
      miscompares++;
      $display("FAIL busy_hold: got %h expected %h", bus.o_SETID_MOD, exp_a);
    end
    // Request C captured at E15, the earliest legal slot.
    run_request(id_c, ram_c, lat, res, single);
    vectors++;
    if (lat != 13 || res !== exp_c) begin
      miscompares++;
      $display("FAIL back_to_back: got lat=%0d word=%h expected 13 word=%h", lat, res, exp_c);
    end
  endtask

  task automatic test_mid_reset();
    logic [VTWID-1:0] res;
    int lat, done_seen;
    logic single;
    bus.i_SET_ID = wild_id(); bus.i_RAM_Data = wild_ram(); bus.i_Status_En = 1'b1;
    tick();
    bus.i_Status_En = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.o_SETID_MOD !== '0 || bus.o_Done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got word=%h done=%b expected 0/0", bus.o_SETID_MOD, bus.o_Done);
    end
    repeat (2) tick();
    rst = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.o_Done === 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL midreset_no_done: got %0d pulses expected 0", done_seen);
    end
    run_request(wild_id(), wild_ram(), lat, res, single);
    vectors++;
    if (lat != 13 || res !== wild_exp() || single !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_recover: got lat=%0d single=%b word=%h expected 13/1 word=%h",
               lat, single, res, wild_exp());
    end
  endtask

  initial begin
    bus.i_SET_ID    = '0;
    bus.i_RAM_Data  = '0;
    bus.i_Status_En = 1'b0;
    test_reset();
    test_empty_ram();
    test_valid_compare();
    test_wildcard_shared();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
